// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (IF) and data memory (DM); ARB_RR_EN selects round-robin, else fixed DM priority with IF anti-starvation.
// Latency: grant is combinational in the request cycle, read data returns with a tagged valid exactly one cycle after the grant.
// Backpressure: a losing requester sees its stall flag and must hold its request; nothing is queued inside.
module mem_port_arbiter #(
    parameter int D_SIZE        = 32,
    parameter int ADDR_LINE_MEM = 10,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     if_req,
    input  logic [ADDR_LINE_MEM-1:0] if_addr,
    output logic                     if_gnt,
    output logic                     if_rvalid,
    output logic                     if_stall,
    input  logic                     dm_req,
    input  logic                     dm_we,
    input  logic [ADDR_LINE_MEM-1:0] dm_addr,
    input  logic [D_SIZE-1:0]        dm_wdata,
    output logic                     dm_gnt,
    output logic                     dm_rvalid,
    output logic                     dm_stall,
    output logic [D_SIZE-1:0]        rdata,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDR_LINE_MEM-1:0] mem_addr,
    output logic [D_SIZE-1:0]        mem_wdata,
    input  logic [D_SIZE-1:0]        mem_rdata
);

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_IF   = 2'd1,
        SRC_DM   = 2'd2
    } src_t;

    typedef struct packed {
        logic                     en;
        logic                     we;
        logic [ADDR_LINE_MEM-1:0] addr;
        logic [D_SIZE-1:0]        wdata;
    } mem_cmd_t;

    src_t     rtag, rtag_nxt;
    mem_cmd_t cmd;
    logic     if_win;

`ifdef ARB_RR_EN
    // Previous winner only matters for the round-robin tie-break.
    src_t last_gnt, last_gnt_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_gnt <= SRC_NONE;
        end else begin
            last_gnt <= last_gnt_nxt;
        end
    end

    always_comb begin
        last_gnt_nxt = last_gnt;
        if (if_gnt) begin
            last_gnt_nxt = SRC_IF;
        end else if (dm_gnt) begin
            last_gnt_nxt = SRC_DM;
        end
    end

    assign if_win = (last_gnt == SRC_DM);
`else
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt, starve_cnt_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt_nxt;
        end
    end

    always_comb begin
        starve_cnt_nxt = starve_cnt;
        if (!if_req || if_gnt) begin
            starve_cnt_nxt = '0;
        end else if (if_stall && (starve_cnt != LIMIT)) begin
            starve_cnt_nxt = starve_cnt + 4'd1;
        end
    end

    assign if_win = (starve_cnt == LIMIT);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rtag <= SRC_NONE;
        end else begin
            rtag <= rtag_nxt;
        end
    end

    // Grants are held off while reset is asserted so every output reads 0.
    always_comb begin
        if_gnt   = 1'b0;
        dm_gnt   = 1'b0;
        rtag_nxt = SRC_NONE;
        cmd      = '0;
        if (reset) begin
            if (if_req && (!dm_req || if_win)) begin
                if_gnt = 1'b1;
            end else if (dm_req) begin
                dm_gnt = 1'b1;
            end
        end
        if (if_gnt) begin
            cmd.en   = 1'b1;
            cmd.addr = if_addr;
            rtag_nxt = SRC_IF;
        end else if (dm_gnt) begin
            cmd.en    = 1'b1;
            cmd.we    = dm_we;
            cmd.addr  = dm_addr;
            cmd.wdata = dm_wdata;
            rtag_nxt  = dm_we ? SRC_NONE : SRC_DM;
        end
    end

    assign if_stall  = reset & if_req & ~if_gnt;
    assign dm_stall  = reset & dm_req & ~dm_gnt;
    assign mem_en    = cmd.en;
    assign mem_we    = cmd.we;
    assign mem_addr  = cmd.addr;
    assign mem_wdata = cmd.wdata;
    assign if_rvalid = (rtag == SRC_IF);
    assign dm_rvalid = (rtag == SRC_DM);
    assign rdata     = (rtag != SRC_NONE) ? mem_rdata : '0;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter that shares the single-port data memory between the instruction-fetch requester (IF) and the MEM-stage data requester (DM). It sits between the pipeline and the memory array. Each cycle it selects one requester, drives the memory port, and routes the one-cycle-latency read data back with a tagged valid. It also raises per-port stall outputs so the pipeline holds while it waits for a grant.

## Interface
Parameters:
- D_SIZE, 32, data word width
- ADDR_LINE_MEM, 10, memory address width
- STARVE_LIMIT, 4, cycles IF may wait under fixed priority before a forced grant (min 1, max 15)

Ports (clock/reset: one clock; reset is asynchronous and active-low):
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous active-low reset
- if_req  input  1  fetch request; holds until if_gnt
- if_addr  input  ADDR_LINE_MEM  fetch address
- if_gnt  output  1  fetch access issued this cycle
- if_rvalid  output  1  fetch read data valid
- if_stall  output  1  if_req & ~if_gnt
- dm_req  input  1  data request; holds until dm_gnt
- dm_we  input  1  1 = write (STW), 0 = read (LDW)
- dm_addr  input  ADDR_LINE_MEM  data address
- dm_wdata  input  D_SIZE  store data
- dm_gnt  output  1  data access issued this cycle
- dm_rvalid  output  1  load data valid (reads only)
- dm_stall  output  1  dm_req & ~dm_gnt
- rdata  output  D_SIZE  read data, shared by both ports
- mem_en  output  1  memory access strobe
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_LINE_MEM  memory address
- mem_wdata  output  D_SIZE  memory write data
- mem_rdata  input  D_SIZE  memory read data, valid one cycle after a read

## Operation
- Grant logic is combinational from the requests and the registered state. Memory-side outputs are a combinational mux of the granted port.
- At most one grant per cycle; mem_en = if_gnt | dm_gnt. Issue is fully pipelined, so a new access can be granted every cycle.
- IF accesses are always reads (mem_we = 0). DM drives mem_we = dm_we and mem_wdata = dm_wdata.
- When not granted: mem_addr = 0, mem_wdata = 0, mem_we = 0.
- Arbitration state register last_gnt ∈ {NONE, IF, DM}.
  - Reset value: NONE.
  - Updates to the port granted each cycle; holds when idle.
- Response tag register rtag ∈ {NONE, IF, DM}.
  - Set to IF on an IF grant, to DM on a DM read grant, otherwise NONE.
  - In cycle N+1: if_rvalid = (rtag==IF), dm_rvalid = (rtag==DM), rdata = mem_rdata when a valid is high, else 0.
- A DM write produces no rvalid.
- Only one requester active: grant it immediately.
- Both requesting: policy selected by configuration (below).
- Starvation counter (4 bits, fixed-priority build only):
  - Increments each cycle IF is stalled.
  - Clears on if_gnt or when if_req is low.
  - Saturates at STARVE_LIMIT.
- Reset mid-operation: an outstanding read is discarded (no rvalid), and the counter clears.

## Timing
- Reset values: every output 0; last_gnt = NONE; rtag = NONE; counter = 0.
- Latency:
  - Request to grant: 0 cycles when the port wins.
  - Grant to rvalid: exactly 1 cycle.
- Request inputs sampled only in the grant cycle. The requester may change them in the cycle after its grant.
- A requester dropping req without a grant is legal; no access is issued for it.
- Back-to-back: the same port may be granted on consecutive cycles when the other port is idle.

## Configuration
- ARB_RR_EN defined: round-robin. On contention, grant the port opposite last_gnt; from NONE, DM wins. The starvation counter is not built.
- ARB_RR_EN undefined: fixed priority, DM wins on contention. Exception: when the counter equals STARVE_LIMIT, IF wins that cycle and the counter clears.

## Test plan
- Reset: assert reset low with if_req = 1 mid-read. All outputs 0 immediately; no if_rvalid after release.
- IF only: if_req = 1, if_addr = 0x005, mem_rdata = 0xDEADBEEF next cycle. if_gnt in cycle N; if_rvalid = 1 and rdata = 0xDEADBEEF in N+1.
- DM write then read:
  - Cycle N: dm_we = 1, addr 0x010, data 0x12345678. dm_gnt, mem_we = 1, no dm_rvalid.
  - Cycle N+1: read of 0x010. dm_rvalid in N+2.
- Contention, ARB_RR_EN defined: both requesting for 4 cycles from reset. Grant order DM, IF, DM, IF.
- Contention, ARB_RR_EN undefined, STARVE_LIMIT = 4: both requesting continuously. DM granted 4 cycles, IF granted in cycle 5, then DM again.
- Stall flags: dm_req held while IF is forced. dm_stall = 1 exactly in the forced-IF cycle; if_stall = 1 in the 4 prior cycles.
